// File: rtl/conv_stream_feeder.sv
// Streams weight words and column-pair fmap beats to the CONV core.
// Walks kernel -> channel -> output row -> column pair, with stall, weight reload and position tags.
module conv_stream_feeder #(
  parameter int DW      = 8,
  parameter int K       = 4,
  parameter int FW      = 64,
  parameter int CH_STEP = 8,
  parameter int ROW_GAP = 2,
  parameter int WRELOAD = 1,
  parameter int AW      = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             cfg_ci,
  input  logic [1:0]             cfg_co,
  input  logic                   stall,
  output logic [AW-1:0]          w_raddr,
  output logic                   w_ren,
  input  logic [2*K*DW-1:0]      w_rdata,
  output logic [K*AW-1:0]        f_raddr,
  output logic                   f_ren,
  input  logic [K*2*DW-1:0]      f_rdata,
  output logic [2*K*DW-1:0]      wdata,
  output logic                   wvalid,
  output logic [2*K*DW-1:0]      fdata,
  output logic                   fvalid,
  output logic [4:0]             tag_ko,
  output logic [4:0]             tag_ci,
  output logic [$clog2(FW)-1:0]  tag_row,
  output logic                   row_last,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(4*CH_STEP);
  localparam int RW = $clog2(FW);
  localparam int BW = $clog2(K);
  localparam int GW = $clog2(ROW_GAP + 2);
  localparam logic [RW-1:0] ROW_END = RW'(FW - K);
  localparam logic [RW-1:0] COL_END = RW'(FW/2 - 1);
  localparam logic [BW-1:0] WB_END  = BW'(K/2 - 1);
  localparam logic [GW-1:0] GAP_END = GW'(ROW_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_WGT, S_FMAP, S_GAP, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ko_q, ko_d, ci_q, ci_d, ko_end_q, ko_end_d, ci_end_q, ci_end_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic [BW-1:0]   wbeat_q, wbeat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            wvalid_q, wvalid_d, fvalid_q, fvalid_d;
  logic            row_last_q, row_last_d, busy_q, busy_d, done_q, done_d;
  logic [4:0]      tag_ko_q, tag_ko_d, tag_ci_q, tag_ci_d;
  logic [RW-1:0]   tag_row_q, tag_row_d;

  logic            row_wrap, ci_wrap, ko_wrap, run_end;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_ci, nxt_ko;
  state_t          nxt_row_state;

  assign w_ren = (state_q == S_WGT)  && !stall;
  assign f_ren = (state_q == S_FMAP) && !stall;

  // Position of the row that follows the current one, with carries into ci and ko.
  always_comb begin
    row_wrap = (row_q == ROW_END);
    ci_wrap  = (ci_q == ci_end_q);
    ko_wrap  = (ko_q == ko_end_q);
    run_end  = row_wrap && ci_wrap && ko_wrap;
    nxt_row  = row_wrap ? '0 : row_q + 1'b1;
    nxt_ci   = ci_q;
    nxt_ko   = ko_q;
    if (row_wrap) begin
      nxt_ci = ci_wrap ? '0 : ci_q + 1'b1;
      if (ci_wrap) nxt_ko = ko_wrap ? '0 : ko_q + 1'b1;
    end
    nxt_row_state = (WRELOAD != 0 || nxt_row == '0) ? S_WGT : S_FMAP;
  end

  always_comb begin
    state_d    = state_q;
    ko_d       = ko_q;
    ci_d       = ci_q;
    ko_end_d   = ko_end_q;
    ci_end_d   = ci_end_q;
    row_d      = row_q;
    col_d      = col_q;
    wbeat_d    = wbeat_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wvalid_d   = w_ren;
    fvalid_d   = f_ren;
    tag_ko_d   = tag_ko_q;
    tag_ci_d   = tag_ci_q;
    tag_row_d  = tag_row_q;
    row_last_d = row_last_q;
    if (f_ren) begin
      tag_ko_d   = 5'(ko_q);
      tag_ci_d   = 5'(ci_q);
      tag_row_d  = row_q;
      row_last_d = (col_q == COL_END);
    end
    if (!stall) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          ci_end_d = CW'((int'(cfg_ci) + 1) * CH_STEP - 1);
          ko_end_d = CW'((int'(cfg_co) + 1) * CH_STEP - 1);
          ko_d     = '0;
          ci_d     = '0;
          row_d    = '0;
          col_d    = '0;
          wbeat_d  = '0;
          gap_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WGT;
        end
        S_WGT: begin
          if (wbeat_q == WB_END) begin
            wbeat_d = '0;
            state_d = S_FMAP;
          end else begin
            wbeat_d = wbeat_q + 1'b1;
          end
        end
        S_FMAP: begin
          if (col_q == COL_END) begin
            col_d = '0;
            if (run_end) begin
              state_d = S_FLUSH;
            end else if (ROW_GAP > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              row_d   = nxt_row;
              ci_d    = nxt_ci;
              ko_d    = nxt_ko;
              state_d = nxt_row_state;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_END) begin
            row_d   = nxt_row;
            ci_d    = nxt_ci;
            ko_d    = nxt_ko;
            state_d = nxt_row_state;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_FLUSH: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ko_q       <= '0;
      ci_q       <= '0;
      ko_end_q   <= '0;
      ci_end_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wbeat_q    <= '0;
      gap_q      <= '0;
      wvalid_q   <= 1'b0;
      fvalid_q   <= 1'b0;
      row_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tag_ko_q   <= '0;
      tag_ci_q   <= '0;
      tag_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      ko_q       <= ko_d;
      ci_q       <= ci_d;
      ko_end_q   <= ko_end_d;
      ci_end_q   <= ci_end_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wbeat_q    <= wbeat_d;
      gap_q      <= gap_d;
      wvalid_q   <= wvalid_d;
      fvalid_q   <= fvalid_d;
      row_last_q <= row_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tag_ko_q   <= tag_ko_d;
      tag_ci_q   <= tag_ci_d;
      tag_row_q  <= tag_row_d;
    end
  end

  // Addresses are shown only in their issuing state so an idle block drives all zeros.
  logic [AW-1:0] ci_count, w_addr;
  assign ci_count = AW'(ci_end_q) + AW'(1);
  assign w_addr   = (AW'(ko_q) * ci_count + AW'(ci_q)) * AW'(K/2) + AW'(wbeat_q);
  assign w_raddr  = (state_q == S_WGT) ? w_addr : '0;

  for (genvar i = 0; i < K; i++) begin : g_bank
    logic [AW-1:0] bank_addr;
    assign bank_addr = AW'(ci_q) * AW'(FW*(FW/2)) + (AW'(row_q) + AW'(i)) * AW'(FW/2) + AW'(col_q);
    assign f_raddr[i*AW +: AW]   = (state_q == S_FMAP) ? bank_addr : '0;
    assign fdata[i*DW +: DW]     = fvalid_q ? f_rdata[2*i*DW +: DW] : '0;
    assign fdata[(K+i)*DW +: DW] = fvalid_q ? f_rdata[(2*i+1)*DW +: DW] : '0;
  end

  assign wdata    = wvalid_q ? w_rdata : '0;
  assign wvalid   = wvalid_q;
  assign fvalid   = fvalid_q;
  assign tag_ko   = tag_ko_q;
  assign tag_ci   = tag_ci_q;
  assign tag_row  = tag_row_q;
  assign row_last = row_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder (K=4, FW=8): timing, stall, reset, ignored start,
// and a scoreboard of every weight/fmap beat against SRAM models with known contents.
module tb_conv_stream_feeder;
  localparam int DW = 8, K = 4, FW = 8, CH_STEP = 8, AW = 20;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, start2 = 1'b0, stall = 1'b0;
  logic [1:0] cfg_ci = '0, cfg_co = '0;
  logic [AW-1:0] w_raddr, w_raddr2;
  logic w_ren, w_ren2, f_ren, f_ren2;
  logic [K*AW-1:0] f_raddr, f_raddr2;
  logic [63:0] w_rdata = '0, f_rdata = '0, zero64 = '0;
  logic [63:0] wdata, wdata2, fdata, fdata2;
  logic wvalid, wvalid2, fvalid, fvalid2;
  logic [4:0] tag_ko, tag_ci, tag_ko2, tag_ci2;
  logic [2:0] tag_row, tag_row2;
  logic row_last, row_last2, busy, busy2, done, done2;

  int checks = 0, errors = 0;
  int cyc_n = 0, f_cnt = 0, w_cnt = 0, f2_cnt = 0, w2_cnt = 0;
  int done_cnt = 0, done2_cnt = 0, done_cyc = 0, done2_cyc = 0;
  int e_ko = 0, e_ci = 0, e_row = 0, e_col = 0, e_wn = 0;
  logic busy_prev = 1'b0;

  conv_stream_feeder #(.DW(DW), .K(K), .FW(FW), .CH_STEP(CH_STEP), .ROW_GAP(2), .WRELOAD(1), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_ci(cfg_ci), .cfg_co(cfg_co), .stall(stall),
    .w_raddr(w_raddr), .w_ren(w_ren), .w_rdata(w_rdata), .f_raddr(f_raddr), .f_ren(f_ren),
    .f_rdata(f_rdata), .wdata(wdata), .wvalid(wvalid), .fdata(fdata), .fvalid(fvalid),
    .tag_ko(tag_ko), .tag_ci(tag_ci), .tag_row(tag_row), .row_last(row_last), .busy(busy), .done(done));

  conv_stream_feeder #(.DW(DW), .K(K), .FW(FW), .CH_STEP(CH_STEP), .ROW_GAP(0), .WRELOAD(0), .AW(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_ci(cfg_ci), .cfg_co(cfg_co), .stall(stall),
    .w_raddr(w_raddr2), .w_ren(w_ren2), .w_rdata(zero64), .f_raddr(f_raddr2), .f_ren(f_ren2),
    .f_rdata(zero64), .wdata(wdata2), .wvalid(wvalid2), .fdata(fdata2), .fvalid(fvalid2),
    .tag_ko(tag_ko2), .tag_ci(tag_ci2), .tag_row(tag_row2), .row_last(row_last2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(int c, int y, int x);
    return 8'(c*29 + y*11 + x*3 + 1);
  endfunction

  function automatic logic [63:0] w_word(logic [19:0] a);
    logic [63:0] v;
    for (int l = 0; l < 8; l++) v[l*8 +: 8] = 8'(int'(a)*5 + l*17 + 3);
    return v;
  endfunction

  function automatic logic [63:0] f_word_all(logic [79:0] ra);
    logic [63:0] v;
    int a, c, y, col;
    for (int i = 0; i < 4; i++) begin
      a   = int'(ra[i*20 +: 20]);
      c   = a / 32;
      y   = (a % 32) / 4;
      col = a % 4;
      v[i*16 +: 8]     = pix(c, y, 2*col);
      v[i*16 + 8 +: 8] = pix(c, y, 2*col + 1);
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_fdata(int c, int r, int col);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i*8 +: 8]     = pix(c, r + i, 2*col);
      v[(4+i)*8 +: 8] = pix(c, r + i, 2*col + 1);
    end
    return v;
  endfunction

  // SRAM models: one-cycle read latency, contents given by w_word / pix.
  always @(posedge clk) begin
    if (w_ren) w_rdata <= w_word(w_raddr);
    if (f_ren) f_rdata <= f_word_all(f_raddr);
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic s2, input logic [1:0] ci,
                               input logic [1:0] co, input logic st);
    start  = s;
    start2 = s2;
    cfg_ci = ci;
    cfg_co = co;
    stall  = st;
  endtask

  // One clock: sample at the falling edge and score every beat against the expected walk.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      e_ko = 0; e_ci = 0; e_row = 0; e_col = 0; e_wn = 0;
    end
    busy_prev = busy;
    if (fvalid === 1'b1) begin
      f_cnt++;
      checkOutput("ftag", {tag_ko, tag_ci, tag_row, row_last},
                  {5'(e_ko), 5'(e_ci), 3'(e_row), (e_col == 3)});
      checkOutput("fdata", fdata, exp_fdata(e_ci, e_row, e_col));
      if (e_col == 3) begin
        e_col = 0;
        if (e_row == 4) begin
          e_row = 0;
          if (e_ci == 7) begin e_ci = 0; e_ko++; end
          else e_ci++;
        end else e_row++;
      end else e_col++;
    end
    if (wvalid === 1'b1) begin
      w_cnt++;
      checkOutput("wdata", wdata, w_word(20'((e_wn/10)*2 + e_wn%2)));
      e_wn++;
    end
    if (wvalid2 === 1'b1) w2_cnt++;
    if (fvalid2 === 1'b1) f2_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc_n; end
    if (done2 === 1'b1) begin done2_cnt++; done2_cyc = cyc_n; end
  endtask

  initial begin
    int c0, f0, w0, d0, n;
    applyStimulus(0, 0, 2'd0, 2'd0, 0);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_ctl", {busy, done, w_ren, f_ren, wvalid, fvalid, row_last}, 7'd0);
    checkOutput("rst_waddr", w_raddr, 0);
    checkOutput("rst_faddr", f_raddr, 0);
    checkOutput("rst_data", {wdata, fdata}, 0);
    checkOutput("rst_tags", {tag_ko, tag_ci, tag_row}, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: both instances, cfg 0/0, with a 3-cycle stall at column 3 of the first row.
    applyStimulus(1, 1, 2'd0, 2'd0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 2'd0, 0);
    c0 = cyc_n;
    checkOutput("c1_ctl", {busy, w_ren, f_ren, wvalid}, 4'b1100);
    checkOutput("c1_waddr", w_raddr, 0);
    tick();
    checkOutput("c2_ctl", {w_ren, wvalid}, 2'b11);
    checkOutput("c2_waddr", w_raddr, 1);
    tick();
    checkOutput("c3_ctl", {w_ren, f_ren, wvalid, fvalid}, 4'b0110);
    checkOutput("c3_faddr", f_raddr, {20'd12, 20'd8, 20'd4, 20'd0});
    tick();
    checkOutput("c4_faddr", f_raddr, {20'd13, 20'd9, 20'd5, 20'd1});
    checkOutput("c4_fvalid", fvalid, 1);
    tick();
    checkOutput("c5_faddr", f_raddr, {20'd14, 20'd10, 20'd6, 20'd2});
    tick();
    checkOutput("c6_faddr", f_raddr, {20'd15, 20'd11, 20'd7, 20'd3});
    checkOutput("c6_fvalid", fvalid, 1);
    applyStimulus(0, 0, 2'd0, 2'd0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_faddr", f_raddr, {20'd15, 20'd11, 20'd7, 20'd3});
      checkOutput("stall_ctl", {f_ren, fvalid, busy}, 3'b001);
    end
    applyStimulus(0, 0, 2'd0, 2'd0, 0);
    tick();
    checkOutput("resume", {f_ren, fvalid, row_last}, 3'b011);
    n = 0;
    while (done_cnt == 0 && n < 4000) begin tick(); n++; end
    checkOutput("run1_done_seen", done_cnt, 1);
    checkOutput("run1_latency", done_cyc - c0, 2562);
    checkOutput("run1_busy_at_done", busy, 0);
    checkOutput("run1_fbeats", f_cnt, 1280);
    checkOutput("run1_wbeats", w_cnt, 640);
    checkOutput("noreload_done", done2_cnt, 1);
    checkOutput("noreload_latency", done2_cyc - c0, 1412);
    checkOutput("noreload_wbeats", w2_cnt, 128);
    checkOutput("noreload_fbeats", f2_cnt, 1280);
    tick();
    checkOutput("done_pulse", {done, busy}, 2'b00);

    // Run 2: asynchronous reset in the middle of ci=3, then a clean restart.
    tick();
    applyStimulus(1, 0, 2'd0, 2'd0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 2'd0, 0);
    repeat (123) tick();
    checkOutput("pre_rst_ci", {fvalid, f_ren, tag_ci}, {2'b11, 5'd3});
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctl", {busy, done, w_ren, f_ren, wvalid, fvalid, row_last}, 7'd0);
    checkOutput("async_rst_faddr", f_raddr, 0);
    checkOutput("async_rst_data", fdata, 0);
    checkOutput("async_rst_tags", {tag_ko, tag_ci, tag_row}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("no_autostart", {busy, w_ren, f_ren}, 3'b000);

    // Run 3: restart from the top; a start pulse and cfg change mid-run must be ignored.
    f0 = f_cnt; w0 = w_cnt; d0 = done_cnt;
    applyStimulus(1, 0, 2'd0, 2'd0, 0);
    tick();
    applyStimulus(0, 0, 2'd0, 2'd0, 0);
    c0 = cyc_n;
    checkOutput("restart_c1", {busy, w_ren}, 2'b11);
    checkOutput("restart_waddr", w_raddr, 0);
    repeat (3) tick();
    checkOutput("restart_tag", {fvalid, tag_ko, tag_ci, tag_row}, {1'b1, 13'd0});
    repeat (50) tick();
    applyStimulus(1, 0, 2'd3, 2'd3, 0);
    repeat (3) tick();
    applyStimulus(0, 0, 2'd3, 2'd3, 0);
    checkOutput("busy_after_spurious", busy, 1);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin tick(); n++; end
    checkOutput("run3_done_seen", done_cnt - d0, 1);
    checkOutput("run3_latency", done_cyc - c0, 2559);
    checkOutput("run3_fbeats", f_cnt - f0, 1280);
    checkOutput("run3_wbeats", w_cnt - w0, 640);
    repeat (3) tick();
    checkOutput("idle_after_run3", {busy, done, w_ren, f_ren}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
